// File: rtl/vending_machine_param.sv
// Parametrised Moore vending-machine controller: accepts coded coins, vends at PRICE,
// and streams change or refunds one unit per cycle. Credit is kept in half-yuan units.
module vending_machine_param #(
    parameter int CW         = 6,
    parameter int PRICE      = 4,
    parameter int VAL_A      = 1,
    parameter int VAL_B      = 2,
    parameter int VAL_C      = 10,
    parameter int MAX_CREDIT = 20
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [1:0]    coin,
    input  logic          cancel,
    output logic          sell,
    output logic          change_pulse,
    output logic          coin_rej,
    output logic          busy,
    output logic [CW-1:0] credit
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        VEND    = 2'b10,
        CHANGE  = 2'b11
    } state_e;

    localparam logic [CW:0]   PRICE_X = (CW+1)'(PRICE);
    localparam logic [CW:0]   MAX_X   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW-1:0] PRICE_C = CW'(PRICE);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          coin_rej_q, coin_rej_d;

    logic [CW:0]   coin_val;
    logic [CW:0]   sum;

    always_comb begin
        coin_val = '0;
        case (coin)
            2'b01:   coin_val = (CW+1)'(VAL_A);
            2'b10:   coin_val = (CW+1)'(VAL_B);
            2'b11:   coin_val = (CW+1)'(VAL_C);
            default: coin_val = '0;
        endcase
    end

    // One extra bit so an overflowing sum is still compared correctly against MAX_CREDIT.
    assign sum = {1'b0, credit_q} + coin_val;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        coin_rej_d = 1'b0;
        case (state_q)
            IDLE, COLLECT: begin
                if ((state_q == COLLECT) && cancel) begin
                    state_d    = CHANGE;
                    coin_rej_d = (coin != 2'b00);
                end else if (coin != 2'b00) begin
                    if (sum > MAX_X) begin
                        coin_rej_d = 1'b1;
                    end else begin
                        credit_d = sum[CW-1:0];
                        state_d  = (sum >= PRICE_X) ? VEND : COLLECT;
                    end
                end
            end
            VEND: begin
                coin_rej_d = (coin != 2'b00);
                credit_d   = credit_q - PRICE_C;
                state_d    = (credit_q > PRICE_C) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_rej_d = (coin != 2'b00);
                credit_d   = credit_q - ONE_C;
                if (credit_q <= ONE_C) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            credit_q   <= '0;
            coin_rej_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            coin_rej_q <= coin_rej_d;
        end
    end

    assign sell         = (state_q == VEND);
    assign change_pulse = (state_q == CHANGE);
    assign busy         = (state_q == VEND) || (state_q == CHANGE);
    assign coin_rej     = coin_rej_q;
    assign credit       = credit_q;

endmodule
